// File: rtl/param_counter_pkg.sv
// param_counter_pkg: mode codes and one-shot FSM encoding shared by the counter files
package param_counter_pkg;
  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
endpackage

// File: rtl/param_counter_if.sv
// param_counter_if: control inputs and registered status outputs of param_counter
interface param_counter_if #(parameter int WIDTH = 7) ();
  logic             clr;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             dir;
  logic [1:0]       mode;
  logic             start;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;
  modport master (output clr, en, load, load_val, dir, mode, start, input count, tc, busy, done);
  modport slave  (input clr, en, load, load_val, dir, mode, start, output count, tc, busy, done);
endinterface

// File: rtl/param_counter_step.sv
// count_step: next count value and boundary flag for one enabled step
module count_step
  import param_counter_pkg::*;
#(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic [WIDTH-1:0] count,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] nxt,
  output logic             at_bnd
);
  always_comb begin
    at_bnd = dir ? count == MAX : count == '0;
    nxt    = !at_bnd ? (dir ? count + WIDTH'(1) : count - WIDTH'(1))
           : (mode == MODE_SAT || mode == MODE_ONESHOT) ? count
           : (dir ? '0 : MAX);
  end
endmodule

// File: rtl/param_counter.sv
// param_counter: up/down counter with wrap, saturate and one-shot modes
module param_counter
  import param_counter_pkg::*;
#(
  parameter int              WIDTH = 7,
  parameter longint unsigned MAX   = (64'd1 << WIDTH) - 1
) (
  input logic            clk,
  input logic            rst,
  param_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX_V = MAX[WIDTH-1:0];
  if (WIDTH < 2 || WIDTH > 32 || MAX < 1 || MAX > (64'd1 << WIDTH) - 1) begin : g_bad_param
    $error("param_counter: WIDTH or MAX out of range");
  end
  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, step_val, load_clamped;
  logic             tc_q, tc_d, busy_q, busy_d, done_q, done_d, ldir_q, ldir_d;
  logic [1:0]       lmode_q, lmode_d, eff_mode;
  logic             run, eff_dir, at_bnd, launch, step;
  // a running one-shot follows the direction and mode captured at launch
  assign run      = state_q == ST_RUN;
  assign eff_dir  = run ? ldir_q : bus.dir;
  assign eff_mode = run ? lmode_q : bus.mode;
  count_step #(.WIDTH(WIDTH), .MAX(MAX_V)) u_step (
    .count (count_q),
    .dir   (eff_dir),
    .mode  (eff_mode),
    .nxt   (step_val),
    .at_bnd(at_bnd)
  );
  always_comb begin
    load_clamped = bus.load_val > MAX_V ? MAX_V : bus.load_val;
    launch       = state_q == ST_IDLE && bus.mode == MODE_ONESHOT && bus.start;
    step         = bus.en && (run || (state_q == ST_IDLE && bus.mode != MODE_ONESHOT));
    count_d      = count_q;
    tc_d         = 1'b0;
    state_d      = state_q == ST_DONE ? ST_IDLE : state_q;
    ldir_d       = ldir_q;
    lmode_d      = lmode_q;
    if (bus.clr) begin
      count_d = '0;
      state_d = ST_IDLE;
    end else if (bus.load) begin
      count_d = load_clamped;
    end else if (launch) begin
      count_d = bus.dir ? '0 : MAX_V;
      ldir_d  = bus.dir;
      lmode_d = bus.mode;
      state_d = ST_RUN;
    end else if (step) begin
      count_d = step_val;
      tc_d    = at_bnd;
      state_d = run && at_bnd ? ST_DONE : state_d;
    end
    busy_d = state_d == ST_RUN;
    done_d = state_d == ST_DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ldir_q  <= 1'b1;
      lmode_q <= MODE_WRAP;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ldir_q  <= ldir_d;
      lmode_q <= lmode_d;
    end
  end
  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule
